// File: rtl/term_writer_if.sv
// Character input handshake and character-buffer port of the terminal writer.
// A character transfers on any clk edge where in_valid and in_ready are both 1;
// the producer holds in_char stable while in_valid is high and in_ready is low.
interface term_writer_if;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic [11:0] buf_addr;
    logic [7:0]  buf_wdata;
    logic        buf_we;
    logic [7:0]  buf_rdata;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;

    modport master (
        input  in_valid, in_char, buf_rdata,
        output in_ready, buf_addr, buf_wdata, buf_we, cursor_row, cursor_col, busy
    );

    modport slave (
        output in_valid, in_char, buf_rdata,
        input  in_ready, buf_addr, buf_wdata, buf_we, cursor_row, cursor_col, busy
    );
endinterface

// File: rtl/term_writer.sv
// Text terminal writer: clears the screen buffer, places characters at the cursor,
// handles LF/CR/BS, and scrolls the buffer up one row when the bottom is passed.
module term_writer #(
    parameter int          COLS  = 70,
    parameter int          ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic             clk,
    input  logic             rst_n,
    term_writer_if.master    bus,
    output logic [2:0]       o_dbg_state
);
    typedef enum logic [2:0] {INIT, IDLE, EXEC, SC_RD, SC_WR, SC_CLR} state_t;

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt_row, w_cnt_row_nxt;
    logic [6:0]  r_cnt_col, w_cnt_col_nxt;
    logic [4:0]  r_cur_row, w_cur_row_nxt;
    logic [6:0]  r_cur_col, w_cur_col_nxt;
    logic [7:0]  r_char, w_char_nxt;
    logic [11:0] r_buf_addr, w_addr_nxt;
    logic [7:0]  r_buf_wdata, w_wdata_nxt;
    logic        r_buf_we, w_we_nxt;
    logic        w_scroll;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    // Bus registers are loaded with the action of the state being entered,
    // so buf_* always describe what the current state is doing this cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_row_nxt = r_cnt_row;
        w_cnt_col_nxt = r_cnt_col;
        w_cur_row_nxt = r_cur_row;
        w_cur_col_nxt = r_cur_col;
        w_char_nxt    = r_char;
        w_addr_nxt    = r_buf_addr;
        w_wdata_nxt   = r_buf_wdata;
        w_we_nxt      = 1'b0;
        w_scroll      = 1'b0;
        case (r_state)
            INIT: begin
                if (r_buf_we && r_buf_addr == {LAST_ROW, LAST_COL}) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = {r_cnt_row, r_cnt_col};
                    w_wdata_nxt = BLANK;
                    if (r_cnt_col == LAST_COL) begin
                        w_cnt_col_nxt = 7'd0;
                        w_cnt_row_nxt = r_cnt_row + 5'd1;
                    end else begin
                        w_cnt_col_nxt = r_cnt_col + 7'd1;
                    end
                end
            end
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = EXEC;
                    w_char_nxt  = bus.in_char;
                    if (is_printable(bus.in_char)) begin
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = {r_cur_row, r_cur_col};
                        w_wdata_nxt = bus.in_char;
                    end else if (bus.in_char == CH_BS) begin
                        if (r_cur_col != 7'd0) begin
                            w_we_nxt    = 1'b1;
                            w_addr_nxt  = {r_cur_row, r_cur_col - 7'd1};
                            w_wdata_nxt = BLANK;
                        end else if (r_cur_row != 5'd0) begin
                            w_we_nxt    = 1'b1;
                            w_addr_nxt  = {r_cur_row - 5'd1, LAST_COL};
                            w_wdata_nxt = BLANK;
                        end
                    end
                end
            end
            EXEC: begin
                w_state_nxt = IDLE;
                if (is_printable(r_char)) begin
                    if (r_cur_col == LAST_COL) begin
                        if (r_cur_row == LAST_ROW) begin
                            w_scroll = 1'b1;
                        end else begin
                            w_cur_col_nxt = 7'd0;
                            w_cur_row_nxt = r_cur_row + 5'd1;
                        end
                    end else begin
                        w_cur_col_nxt = r_cur_col + 7'd1;
                    end
                end else if (r_char == CH_LF) begin
                    if (r_cur_row == LAST_ROW) begin
                        w_scroll = 1'b1;
                    end else begin
                        w_cur_col_nxt = 7'd0;
                        w_cur_row_nxt = r_cur_row + 5'd1;
                    end
                end else if (r_char == CH_CR) begin
                    w_cur_col_nxt = 7'd0;
                end else if (r_char == CH_BS) begin
                    if (r_cur_col != 7'd0) begin
                        w_cur_col_nxt = r_cur_col - 7'd1;
                    end else if (r_cur_row != 5'd0) begin
                        w_cur_row_nxt = r_cur_row - 5'd1;
                        w_cur_col_nxt = LAST_COL;
                    end
                end
                // Cursor holds through the scroll; SC_CLR parks it at (ROWS-1, 0).
                if (w_scroll) begin
                    w_cnt_col_nxt = 7'd0;
                    if (ROWS > 1) begin
                        w_state_nxt   = SC_RD;
                        w_cnt_row_nxt = 5'd1;
                        w_addr_nxt    = {5'd1, 7'd0};
                    end else begin
                        w_state_nxt = SC_CLR;
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = {LAST_ROW, 7'd0};
                        w_wdata_nxt = BLANK;
                    end
                end
            end
            SC_RD: begin
                w_state_nxt = SC_WR;
                w_we_nxt    = 1'b1;
                w_addr_nxt  = {r_cnt_row - 5'd1, r_cnt_col};
            end
            SC_WR: begin
                if (r_cnt_col == LAST_COL) begin
                    w_cnt_col_nxt = 7'd0;
                    if (r_cnt_row == LAST_ROW) begin
                        w_state_nxt = SC_CLR;
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = {LAST_ROW, 7'd0};
                        w_wdata_nxt = BLANK;
                    end else begin
                        w_state_nxt   = SC_RD;
                        w_cnt_row_nxt = r_cnt_row + 5'd1;
                        w_addr_nxt    = {r_cnt_row + 5'd1, 7'd0};
                    end
                end else begin
                    w_state_nxt   = SC_RD;
                    w_cnt_col_nxt = r_cnt_col + 7'd1;
                    w_addr_nxt    = {r_cnt_row, r_cnt_col + 7'd1};
                end
            end
            SC_CLR: begin
                if (r_cnt_col == LAST_COL) begin
                    w_state_nxt   = IDLE;
                    w_cur_row_nxt = LAST_ROW;
                    w_cur_col_nxt = 7'd0;
                end else begin
                    w_cnt_col_nxt = r_cnt_col + 7'd1;
                    w_we_nxt      = 1'b1;
                    w_addr_nxt    = {LAST_ROW, r_cnt_col + 7'd1};
                    w_wdata_nxt   = BLANK;
                end
            end
            default: w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_cnt_row   <= 5'd0;
            r_cnt_col   <= 7'd0;
            r_cur_row   <= 5'd0;
            r_cur_col   <= 7'd0;
            r_char      <= BLANK;
            r_buf_addr  <= 12'd0;
            r_buf_wdata <= BLANK;
            r_buf_we    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt_row   <= w_cnt_row_nxt;
            r_cnt_col   <= w_cnt_col_nxt;
            r_cur_row   <= w_cur_row_nxt;
            r_cur_col   <= w_cur_col_nxt;
            r_char      <= w_char_nxt;
            r_buf_addr  <= w_addr_nxt;
            r_buf_wdata <= w_wdata_nxt;
            r_buf_we    <= w_we_nxt;
        end
    end

    // Read data only arrives during SC_WR itself, so the copy path bypasses the data register.
    assign bus.buf_wdata  = (r_state == SC_WR) ? bus.buf_rdata : r_buf_wdata;
    assign bus.buf_addr   = r_buf_addr;
    assign bus.buf_we     = r_buf_we;
    assign bus.in_ready   = (r_state == IDLE);
    assign bus.busy       = (r_state == INIT) || (r_state == SC_RD) ||
                            (r_state == SC_WR) || (r_state == SC_CLR);
    assign bus.cursor_row = r_cur_row;
    assign bus.cursor_col = r_cur_col;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_term_writer.sv
// Randomized scoreboard bench for term_writer: a screen/cursor model predicts every
// buffer write, a monitor pops and compares them, and the driver checks cursor and busy time.
module tb_term_writer;
    localparam int         COLS          = 70;
    localparam int         ROWS          = 30;
    localparam logic [7:0] BLANK         = 8'h20;
    localparam int         SCROLL_CYCLES = 2 * (ROWS - 1) * COLS + COLS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;

    term_writer_if bus();

    term_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Character buffer: synchronous write, registered read.
    logic [7:0] mem [0:4095];
    always @(posedge clk) begin
        if (bus.buf_we) mem[bus.buf_addr] <= bus.buf_wdata;
        bus.buf_rdata <= mem[bus.buf_addr];
    end

    logic [19:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Screen model
    logic [7:0] scr [ROWS][COLS];
    int         cur_r;
    int         cur_c;

    function automatic logic [11:0] mk(input int r, input int c);
        return 12'(r * 128 + c);
    endfunction

    task automatic put(input int r, input int c, input logic [7:0] d);
        exp_q.push_back({mk(r, c), d});
        scr[r][c] = d;
    endtask

    task automatic model_scroll();
        for (int r = 1; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) put(r - 1, c, scr[r][c]);
        for (int c = 0; c < COLS; c++) put(ROWS - 1, c, BLANK);
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) put(r, c, BLANK);
        cur_r = 0;
        cur_c = 0;
    endtask

    task automatic model_apply(input logic [7:0] ch, output bit scrolled);
        scrolled = 1'b0;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            put(cur_r, cur_c, ch);
            cur_c++;
            if (cur_c == COLS) begin
                cur_c = 0;
                if (cur_r == ROWS - 1) begin model_scroll(); scrolled = 1'b1; end
                else cur_r++;
            end
        end else if (ch == 8'h0A) begin
            cur_c = 0;
            if (cur_r == ROWS - 1) begin model_scroll(); scrolled = 1'b1; end
            else cur_r++;
        end else if (ch == 8'h0D) begin
            cur_c = 0;
        end else if (ch == 8'h08) begin
            if (cur_c > 0) begin
                cur_c--;
                put(cur_r, cur_c, BLANK);
            end else if (cur_r > 0) begin
                cur_r--;
                cur_c = COLS - 1;
                put(cur_r, cur_c, BLANK);
            end
        end
    endtask

    // Monitor: every buffer write must be the next expected one.
    logic [19:0] mon_e;
    always @(negedge clk) begin
        if (rst_n && bus.buf_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: addr %03h data %02h, no write expected (t=%0t)",
                         bus.buf_addr, bus.buf_wdata, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("buf_write", {12'd0, bus.buf_addr, bus.buf_wdata}, {12'd0, mon_e});
            end
        end
    end

    task automatic wait_idle(output int busy_cyc);
        int n = 0;
        busy_cyc = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.busy) busy_cyc++;
        end while (!bus.in_ready && n < 10000);
        if (!bus.in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: in_ready 0 after %0d cycles (state %0d), expected 1", n, dbg_state);
        end
    endtask

    task automatic issue(input logic [7:0] ch, output bit scrolled);
        model_apply(ch, scrolled);
        bus.in_char  = ch;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_char  = 8'($urandom_range(0, 255));
    endtask

    task automatic send(input logic [7:0] ch);
        bit s;
        int bc;
        issue(ch, s);
        wait_idle(bc);
        chk("busy_cycles", bc, s ? SCROLL_CYCLES : 0);
        chk("pending_writes", exp_q.size(), 0);
        chk("cursor_row", bus.cursor_row, cur_r);
        chk("cursor_col", bus.cursor_col, cur_c);
    endtask

    task automatic do_reset();
        int bc;
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h41;
        #1;
        chk("rst_buf_we", bus.buf_we, 0);
        chk("rst_buf_addr", bus.buf_addr, 0);
        chk("rst_buf_wdata", bus.buf_wdata, BLANK);
        chk("rst_cursor_row", bus.cursor_row, 0);
        chk("rst_cursor_col", bus.cursor_col, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_busy", bus.busy, 1);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("init_in_ready", bus.in_ready, 0);
        chk("init_busy", bus.busy, 1);
        bus.in_valid = 1'b0;
        wait_idle(bc);
        chk("init_writes_left", exp_q.size(), 0);
        chk("init_cursor_row", bus.cursor_row, 0);
        chk("init_cursor_col", bus.cursor_col, 0);
        chk("init_in_ready_done", bus.in_ready, 1);
    endtask

    task automatic check_screen();
        for (int r = 0; r < ROWS; r++) begin
            int ok = 0;
            for (int c = 0; c < COLS; c++)
                if (mem[mk(r, c)] === scr[r][c]) ok++;
            chk($sformatf("screen_row%0d_matching_cells", r), ok, COLS);
        end
    endtask

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 19))
            0: return 8'h0A;
            1: return 8'h0D;
            2: return 8'h08;
            3: case ($urandom_range(0, 3))
                   0: return 8'h00;
                   1: return 8'h1B;
                   2: return 8'h7F;
                   default: return 8'(8'h80 + $urandom_range(0, 127));
               endcase
            default: return 8'($urandom_range(32, 126));
        endcase
    endfunction

    initial begin
        bit s;
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;

        do_reset();

        send(8'h41);
        send(8'h42);
        chk("ab_cursor_col", bus.cursor_col, 2);

        send(8'h0D);
        repeat (5) send(8'h0A);
        repeat (69) send(8'($urandom_range(32, 126)));
        chk("pre_x_cursor_row", bus.cursor_row, 5);
        chk("pre_x_cursor_col", bus.cursor_col, 69);
        send(8'h58);
        chk("post_x_cursor_row", bus.cursor_row, 6);
        chk("post_x_cursor_col", bus.cursor_col, 0);

        do_reset();
        send(8'h08);
        chk("bs_origin_row", bus.cursor_row, 0);
        chk("bs_origin_col", bus.cursor_col, 0);
        send(8'h0A);
        send(8'h0A);
        send(8'h08);
        chk("bs_wrap_row", bus.cursor_row, 1);
        chk("bs_wrap_col", bus.cursor_col, 69);

        repeat (300) send(rand_char());
        check_screen();

        while (cur_r != ROWS - 1) send(8'h0A);
        send(8'h0D);
        repeat (3) send(8'($urandom_range(32, 126)));
        chk("pre_scroll_row", bus.cursor_row, 29);
        chk("pre_scroll_col", bus.cursor_col, 3);
        send(8'h0A);
        chk("post_scroll_row", bus.cursor_row, 29);
        chk("post_scroll_col", bus.cursor_col, 0);
        check_screen();

        issue(8'h0A, s);
        chk("mid_scroll_entered", s, 1);
        repeat (1000) @(negedge clk);
        chk("mid_scroll_busy", bus.busy, 1);
        do_reset();
        check_screen();

        repeat (60) send(rand_char());
        check_screen();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
